// File: rtl/clock_pkg.sv
// Shared types and helpers for the DE2 digital clock front panel.
// Contents: mode / field / panel-state enums, BCD bus width,
// one-hot destination encoder and edit-field blank mask.
package clock_pkg;

    localparam int BCD_W = 24;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_ALARM     = 2'd1,
        MODE_TIMER     = 2'd2,
        MODE_STOPWATCH = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2
    } field_e;

    typedef enum logic [1:0] {
        ST_VIEW  = 2'd0,
        ST_EDIT  = 2'd1,
        ST_ALERT = 2'd2
    } state_e;

    // One-hot destination for command pulses, bit index = mode number.
    function automatic logic [3:0] mode_onehot(input mode_e m);
        return 4'b0001 << m;
    endfunction

    // Digit pair belonging to a field; bit5 is H1, bit0 is S0.
    function automatic logic [5:0] field_mask(input field_e f);
        logic [5:0] mask;
        case (f)
            FIELD_SEC:  mask = 6'b000011;
            FIELD_MIN:  mask = 6'b001100;
            FIELD_HOUR: mask = 6'b110000;
            default:    mask = 6'b000000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Key input conditioner: 2-flop synchronizer followed by a rising-edge
// detector giving a single-cycle event per press (no auto-repeat).
// Ports: CLK, RSTN (async active-low), key (raw level, 1 = pressed),
//        evt (one-cycle press event).
module key_edge (
    input  logic CLK,
    input  logic RSTN,
    input  logic key,
    output logic evt
);

    logic       sync1_r;
    logic       sync2_r;
    logic       prev_r;
    logic [1:0] fill_r;

    // Synchronizer, previous-sample history and warm-up counter. The edge
    // detector stays quiet until all three flops hold real samples, so a
    // key held through reset release is not mistaken for a press.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            fill_r  <= 2'd0;
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (fill_r != 2'd3) begin
                fill_r <= fill_r + 2'd1;
            end else begin
                fill_r <= fill_r;
            end
        end
    end

    assign evt = (fill_r == 2'd3) & sync2_r & ~prev_r;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-panel controller for the DE2 digital clock. Shares five keys and
// six HEX digits between the clock, alarm, timer and stopwatch blocks.
// Ports:
//   CLK, RSTN                     clock, async active-low reset
//   KEY_MODE/FIELD/RUN/UP/DN      raw key levels, 1 = pressed
//   CLK/ALM/TMR/SW_BCD            {H1,H0,M1,M0,S1,S0} digits per block
//   TMR_ACTIVE, TMR_DONE          timer running / reached-zero pulse
//   MODE, FIELD, EDIT_EN, ALERT   panel state
//   DST, UP_P, DN_P, RUN_P        one-hot destination + command pulses
//   DISP_BCD, DISP_BLANK          selected digits and blink mask
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_PER_SEC    = 5000,
    parameter int BLINK_HALF     = 2500,
    parameter int EDIT_TIMEOUT_S = 10,
    parameter int ALERT_S        = 30
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             KEY_MODE,
    input  logic             KEY_FIELD,
    input  logic             KEY_RUN,
    input  logic             KEY_UP,
    input  logic             KEY_DN,
    input  logic [BCD_W-1:0] CLK_BCD,
    input  logic [BCD_W-1:0] ALM_BCD,
    input  logic [BCD_W-1:0] TMR_BCD,
    input  logic [BCD_W-1:0] SW_BCD,
    input  logic             TMR_ACTIVE,
    input  logic             TMR_DONE,
    output logic [1:0]       MODE,
    output logic [1:0]       FIELD,
    output logic             EDIT_EN,
    output logic [3:0]       DST,
    output logic             UP_P,
    output logic             DN_P,
    output logic             RUN_P,
    output logic [BCD_W-1:0] DISP_BCD,
    output logic [5:0]       DISP_BLANK,
    output logic             ALERT
);

    localparam int SEC_W   = $clog2(CLK_PER_SEC);
    localparam int BLINK_W = $clog2(BLINK_HALF);
    localparam int IDLE_W  = $clog2(EDIT_TIMEOUT_S + 1);
    localparam int ALRT_W  = $clog2(ALERT_S + 1);

    logic ev_mode_s, ev_field_s, ev_run_s, ev_up_s, ev_dn_s, ev_any_s;
    logic sel_mode_s, sel_field_s, sel_run_s, sel_up_s, sel_dn_s;
    logic sec_tick_s, tmr_rise_s, edit_allowed_s, blink_clr_s;

    state_e             state_r;
    mode_e              mode_r;
    field_e             field_r;
    logic               edit_en_r, alert_r, phase_r, tmr_act_d_r;
    logic               up_p_r, dn_p_r, run_p_r;
    logic [3:0]         dst_r;
    logic [BCD_W-1:0]   disp_bcd_r;
    logic [5:0]         disp_blank_r;
    logic [SEC_W-1:0]   sec_cnt_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic [IDLE_W-1:0]  idle_s_r;
    logic [ALRT_W-1:0]  alert_s_r;

    key_edge u_key_mode  (.CLK(CLK), .RSTN(RSTN), .key(KEY_MODE),  .evt(ev_mode_s));
    key_edge u_key_field (.CLK(CLK), .RSTN(RSTN), .key(KEY_FIELD), .evt(ev_field_s));
    key_edge u_key_run   (.CLK(CLK), .RSTN(RSTN), .key(KEY_RUN),   .evt(ev_run_s));
    key_edge u_key_up    (.CLK(CLK), .RSTN(RSTN), .key(KEY_UP),    .evt(ev_up_s));
    key_edge u_key_dn    (.CLK(CLK), .RSTN(RSTN), .key(KEY_DN),    .evt(ev_dn_s));

    assign ev_any_s   = ev_mode_s | ev_field_s | ev_run_s | ev_up_s | ev_dn_s;
    assign sec_tick_s = (sec_cnt_r == SEC_W'(CLK_PER_SEC - 1));
    assign tmr_rise_s = TMR_ACTIVE & ~tmr_act_d_r;
    // The timer may only be edited while it is stopped.
    assign edit_allowed_s = (mode_r == MODE_CLOCK) || (mode_r == MODE_ALARM) ||
                            ((mode_r == MODE_TIMER) && !TMR_ACTIVE);
    // Restart the blink so the digit being edited is shown at once.
    assign blink_clr_s = ((state_r == ST_EDIT) && (sel_up_s || sel_dn_s || sel_field_s)) ||
                         ((state_r == ST_VIEW) && sel_field_s && edit_allowed_s);

    // Fixed-priority pick of one key event per cycle: MODE > FIELD > RUN > UP > DN.
    always_comb begin
        sel_mode_s  = 1'b0;
        sel_field_s = 1'b0;
        sel_run_s   = 1'b0;
        sel_up_s    = 1'b0;
        sel_dn_s    = 1'b0;
        if (ev_mode_s) begin
            sel_mode_s = 1'b1;
        end else if (ev_field_s) begin
            sel_field_s = 1'b1;
        end else if (ev_run_s) begin
            sel_run_s = 1'b1;
        end else if (ev_up_s) begin
            sel_up_s = 1'b1;
        end else if (ev_dn_s) begin
            sel_dn_s = 1'b1;
        end else begin
            sel_mode_s = 1'b0;
        end
    end

    // Panel FSM with seconds base, blink generator and registered outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r      <= ST_VIEW;
            mode_r       <= MODE_CLOCK;
            field_r      <= FIELD_SEC;
            edit_en_r    <= 1'b0;
            alert_r      <= 1'b0;
            phase_r      <= 1'b0;
            tmr_act_d_r  <= 1'b0;
            up_p_r       <= 1'b0;
            dn_p_r       <= 1'b0;
            run_p_r      <= 1'b0;
            dst_r        <= 4'd0;
            disp_bcd_r   <= {BCD_W{1'b0}};
            disp_blank_r <= 6'd0;
            sec_cnt_r    <= {SEC_W{1'b0}};
            blink_cnt_r  <= {BLINK_W{1'b0}};
            idle_s_r     <= {IDLE_W{1'b0}};
            alert_s_r    <= {ALRT_W{1'b0}};
        end else begin
            up_p_r      <= 1'b0;
            dn_p_r      <= 1'b0;
            run_p_r     <= 1'b0;
            dst_r       <= 4'd0;
            tmr_act_d_r <= TMR_ACTIVE;

            if (sec_tick_s) begin
                sec_cnt_r <= {SEC_W{1'b0}};
            end else begin
                sec_cnt_r <= sec_cnt_r + SEC_W'(1);
            end

            if (blink_clr_s) begin
                blink_cnt_r <= {BLINK_W{1'b0}};
                phase_r     <= 1'b0;
            end else if (blink_cnt_r == BLINK_W'(BLINK_HALF - 1)) begin
                blink_cnt_r <= {BLINK_W{1'b0}};
                phase_r     <= ~phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
            end

            case (mode_r)
                MODE_CLOCK:     disp_bcd_r <= CLK_BCD;
                MODE_ALARM:     disp_bcd_r <= ALM_BCD;
                MODE_TIMER:     disp_bcd_r <= TMR_BCD;
                MODE_STOPWATCH: disp_bcd_r <= SW_BCD;
                default:        disp_bcd_r <= {BCD_W{1'b0}};
            endcase

            case (state_r)
                ST_EDIT:  disp_blank_r <= phase_r ? field_mask(field_r) : 6'd0;
                ST_ALERT: disp_blank_r <= phase_r ? 6'b111111 : 6'd0;
                default:  disp_blank_r <= 6'd0;
            endcase

            // Timer expiry overrides everything, including same-cycle keys.
            if (TMR_DONE) begin
                state_r   <= ST_ALERT;
                mode_r    <= MODE_TIMER;
                field_r   <= FIELD_SEC;
                edit_en_r <= 1'b0;
                alert_r   <= 1'b1;
                alert_s_r <= {ALRT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_VIEW: begin
                        if (sel_mode_s) begin
                            mode_r <= mode_e'(mode_r + 2'd1);
                        end else if (sel_field_s && edit_allowed_s) begin
                            state_r   <= ST_EDIT;
                            edit_en_r <= 1'b1;
                            field_r   <= FIELD_SEC;
                            idle_s_r  <= {IDLE_W{1'b0}};
                        end else if (sel_run_s && (mode_r >= MODE_TIMER)) begin
                            run_p_r <= 1'b1;
                            dst_r   <= mode_onehot(mode_r);
                        end else begin
                            state_r <= ST_VIEW;
                        end
                    end
                    ST_EDIT: begin
                        if (tmr_rise_s && (mode_r == MODE_TIMER)) begin
                            state_r   <= ST_VIEW;
                            edit_en_r <= 1'b0;
                            field_r   <= FIELD_SEC;
                        end else if (ev_any_s) begin
                            idle_s_r <= {IDLE_W{1'b0}};
                            if (sel_mode_s) begin
                                state_r   <= ST_VIEW;
                                edit_en_r <= 1'b0;
                                field_r   <= FIELD_SEC;
                            end else if (sel_field_s) begin
                                if (field_r == FIELD_HOUR) begin
                                    state_r   <= ST_VIEW;
                                    edit_en_r <= 1'b0;
                                    field_r   <= FIELD_SEC;
                                end else begin
                                    field_r <= field_e'(field_r + 2'd1);
                                end
                            end else if (sel_run_s) begin
                                state_r   <= ST_VIEW;
                                edit_en_r <= 1'b0;
                                field_r   <= FIELD_SEC;
                                if (mode_r == MODE_TIMER) begin
                                    run_p_r <= 1'b1;
                                    dst_r   <= mode_onehot(mode_r);
                                end else begin
                                    run_p_r <= 1'b0;
                                end
                            end else if (sel_up_s) begin
                                up_p_r <= 1'b1;
                                dst_r  <= mode_onehot(mode_r);
                            end else begin
                                dn_p_r <= 1'b1;
                                dst_r  <= mode_onehot(mode_r);
                            end
                        end else if (sec_tick_s) begin
                            if (idle_s_r == IDLE_W'(EDIT_TIMEOUT_S - 1)) begin
                                state_r   <= ST_VIEW;
                                edit_en_r <= 1'b0;
                                field_r   <= FIELD_SEC;
                            end else begin
                                idle_s_r <= idle_s_r + IDLE_W'(1);
                            end
                        end else begin
                            idle_s_r <= idle_s_r;
                        end
                    end
                    ST_ALERT: begin
                        // The key that dismisses the alert is swallowed.
                        if (ev_any_s) begin
                            state_r <= ST_VIEW;
                            alert_r <= 1'b0;
                        end else if (sec_tick_s) begin
                            if (alert_s_r == ALRT_W'(ALERT_S - 1)) begin
                                state_r <= ST_VIEW;
                                alert_r <= 1'b0;
                            end else begin
                                alert_s_r <= alert_s_r + ALRT_W'(1);
                            end
                        end else begin
                            alert_s_r <= alert_s_r;
                        end
                    end
                    default: begin
                        state_r   <= ST_VIEW;
                        edit_en_r <= 1'b0;
                        alert_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign MODE       = mode_r;
    assign FIELD      = field_r;
    assign EDIT_EN    = edit_en_r;
    assign ALERT      = alert_r;
    assign DST        = dst_r;
    assign UP_P       = up_p_r;
    assign DN_P       = dn_p_r;
    assign RUN_P      = run_p_r;
    assign DISP_BCD   = disp_bcd_r;
    assign DISP_BLANK = disp_blank_r;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: expectations are queued as
// stimulus is applied and compared once the DUT outputs have settled.
module tb_clock_mode_ctrl;

    localparam logic [23:0] CLK_V = 24'h123456;
    localparam logic [23:0] ALM_V = 24'h065900;
    localparam logic [23:0] TMR_V = 24'h000230;
    localparam logic [23:0] SW_V  = 24'h010203;

    localparam int SEL_MODE = 0, SEL_FIELD = 1, SEL_EDIT = 2, SEL_BCD = 3,
                   SEL_BLANK = 4, SEL_ALERT = 5, SEL_UPC = 6, SEL_DNC = 7,
                   SEL_RUNC = 8, SEL_LDST = 9, SEL_DST = 10, SEL_PULSE = 11;

    // key vector order {MODE, FIELD, RUN, UP, DN}
    localparam logic [4:0] K_MODE = 5'b10000, K_FIELD = 5'b01000,
                           K_RUN = 5'b00100, K_UP = 5'b00010, K_DN = 5'b00001;

    logic CLK = 1'b0;
    logic RSTN;
    logic KEY_MODE, KEY_FIELD, KEY_RUN, KEY_UP, KEY_DN;
    logic TMR_ACTIVE, TMR_DONE;
    logic [1:0] MODE, FIELD;
    logic EDIT_EN, UP_P, DN_P, RUN_P, ALERT;
    logic [3:0] DST;
    logic [23:0] DISP_BCD;
    logic [5:0] DISP_BLANK;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int vectors = 0;
    int miscompares = 0;
    int up_cnt = 0, dn_cnt = 0, run_cnt = 0, stray_dst = 0;
    logic [3:0] last_dst = 4'd0;
    logic [1:0] mode_m;

    always #5 CLK = ~CLK;

    clock_mode_ctrl dut (
        .CLK(CLK), .RSTN(RSTN),
        .KEY_MODE(KEY_MODE), .KEY_FIELD(KEY_FIELD), .KEY_RUN(KEY_RUN),
        .KEY_UP(KEY_UP), .KEY_DN(KEY_DN),
        .CLK_BCD(CLK_V), .ALM_BCD(ALM_V), .TMR_BCD(TMR_V), .SW_BCD(SW_V),
        .TMR_ACTIVE(TMR_ACTIVE), .TMR_DONE(TMR_DONE),
        .MODE(MODE), .FIELD(FIELD), .EDIT_EN(EDIT_EN), .DST(DST),
        .UP_P(UP_P), .DN_P(DN_P), .RUN_P(RUN_P),
        .DISP_BCD(DISP_BCD), .DISP_BLANK(DISP_BLANK), .ALERT(ALERT)
    );

    // Pulse monitor: counts command pulses and remembers their destination.
    always @(negedge CLK) begin
        if (UP_P)  begin up_cnt++;  last_dst = DST; end
        if (DN_P)  begin dn_cnt++;  last_dst = DST; end
        if (RUN_P) begin run_cnt++; last_dst = DST; end
        if (DST != 4'd0 && !(UP_P || DN_P || RUN_P)) stray_dst++;
    end

    function automatic logic [23:0] bcd_of(input logic [1:0] m);
        case (m)
            2'd0:    return CLK_V;
            2'd1:    return ALM_V;
            2'd2:    return TMR_V;
            default: return SW_V;
        endcase
    endfunction

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SEL_MODE:  return 32'(MODE);
            SEL_FIELD: return 32'(FIELD);
            SEL_EDIT:  return 32'(EDIT_EN);
            SEL_BCD:   return 32'(DISP_BCD);
            SEL_BLANK: return 32'(DISP_BLANK);
            SEL_ALERT: return 32'(ALERT);
            SEL_UPC:   return 32'(up_cnt);
            SEL_DNC:   return 32'(dn_cnt);
            SEL_RUNC:  return 32'(run_cnt);
            SEL_LDST:  return 32'(last_dst);
            SEL_DST:   return 32'(DST);
            SEL_PULSE: return 32'({UP_P, DN_P, RUN_P});
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, obs(e.sel), e.exp);
        end
    endtask

    task automatic check_now();
        @(negedge CLK);
        drain();
        @(posedge CLK); #1;
    endtask

    task automatic set_keys(input logic [4:0] k);
        {KEY_MODE, KEY_FIELD, KEY_RUN, KEY_UP, KEY_DN} = k;
    endtask

    task automatic press(input logic [4:0] k);
        set_keys(k);
        repeat (6) @(posedge CLK); #1;
        set_keys(5'b0);
        repeat (6) @(posedge CLK); #1;
    endtask

    task automatic pulse_done();
        TMR_DONE = 1'b1;
        @(posedge CLK); #1;
        TMR_DONE = 1'b0;
        repeat (2) @(posedge CLK); #1;
    endtask

    task automatic expect_reset(input string tag);
        expect_val({tag, "_mode"},  SEL_MODE,  32'd0);
        expect_val({tag, "_field"}, SEL_FIELD, 32'd0);
        expect_val({tag, "_edit"},  SEL_EDIT,  32'd0);
        expect_val({tag, "_dst"},   SEL_DST,   32'd0);
        expect_val({tag, "_pulse"}, SEL_PULSE, 32'd0);
        expect_val({tag, "_bcd"},   SEL_BCD,   32'd0);
        expect_val({tag, "_blank"}, SEL_BLANK, 32'd0);
        expect_val({tag, "_alert"}, SEL_ALERT, 32'd0);
    endtask

    // MODE press with a cycle-exact check of the one-cycle display latency.
    task automatic mode_step();
        logic [1:0] old_m;
        int n;
        old_m  = mode_m;
        mode_m = mode_m + 2'd1;
        set_keys(K_MODE);
        n = 0;
        @(negedge CLK);
        while (MODE != mode_m && n < 20) begin
            @(negedge CLK);
            n++;
        end
        expect_val("mode_step", SEL_MODE, 32'(mode_m));
        expect_val("disp_before", SEL_BCD, 32'(bcd_of(old_m)));
        drain();
        @(negedge CLK);
        expect_val("disp_after", SEL_BCD, 32'(bcd_of(mode_m)));
        expect_val("dst_quiet", SEL_DST, 32'd0);
        expect_val("pulse_quiet", SEL_PULSE, 32'd0);
        drain();
        @(posedge CLK); #1;
        set_keys(5'b0);
        repeat (6) @(posedge CLK); #1;
    endtask

    initial begin
        int n, on_cnt, off_cnt, other_cnt;
        RSTN = 1'b0;
        set_keys(5'b0);
        TMR_ACTIVE = 1'b0;
        TMR_DONE   = 1'b0;
        mode_m     = 2'd0;
        repeat (3) @(posedge CLK); #1;
        expect_reset("rst");
        drain();
        RSTN = 1'b1;
        repeat (5) @(posedge CLK); #1;

        // MODE cycling 1,2,3,0,1
        for (int i = 0; i < 5; i++) mode_step();
        expect_val("mode_cnt_up", SEL_UPC, 32'd0);
        expect_val("mode_cnt_run", SEL_RUNC, 32'd0);
        check_now();

        // Timer edit: enter, three UPs
        press(K_MODE); mode_m = 2'd2;
        expect_val("to_timer", SEL_MODE, 32'd2);
        check_now();
        press(K_FIELD);
        expect_val("edit_enter", SEL_EDIT, 32'd1);
        expect_val("edit_field0", SEL_FIELD, 32'd0);
        check_now();
        for (int i = 0; i < 3; i++) press(K_UP);
        expect_val("up3_cnt", SEL_UPC, 32'd3);
        expect_val("up3_dst", SEL_LDST, 32'h4);
        expect_val("up3_dn", SEL_DNC, 32'd0);
        check_now();

        // FIELD and UP together: FIELD wins, UP dropped, blink restarted
        press(K_FIELD | K_UP);
        expect_val("prio_field", SEL_FIELD, 32'd1);
        expect_val("prio_noup", SEL_UPC, 32'd3);
        expect_val("prio_edit", SEL_EDIT, 32'd1);
        expect_val("blink_clr", SEL_BLANK, 32'd0);
        check_now();
        repeat (2500) @(posedge CLK); #1;
        expect_val("blink_min", SEL_BLANK, 32'h0C);
        check_now();

        // RUN in timer edit: leave with RUN_P to timer
        press(K_RUN);
        expect_val("edit_run_cnt", SEL_RUNC, 32'd1);
        expect_val("edit_run_dst", SEL_LDST, 32'h4);
        expect_val("edit_run_exit", SEL_EDIT, 32'd0);
        expect_val("edit_run_mode", SEL_MODE, 32'd2);
        check_now();

        // Running timer cannot be edited; stopwatch RUN
        TMR_ACTIVE = 1'b1;
        press(K_FIELD);
        expect_val("busy_noedit", SEL_EDIT, 32'd0);
        check_now();
        press(K_MODE);
        press(K_RUN);
        expect_val("sw_mode", SEL_MODE, 32'd3);
        expect_val("sw_run_cnt", SEL_RUNC, 32'd2);
        expect_val("sw_run_dst", SEL_LDST, 32'h8);
        check_now();
        TMR_ACTIVE = 1'b0;

        // Clock mode: RUN and DN ignored in VIEW
        press(K_MODE);
        press(K_RUN);
        press(K_DN);
        expect_val("clk_mode", SEL_MODE, 32'd0);
        expect_val("clk_run_ign", SEL_RUNC, 32'd2);
        expect_val("clk_dn_ign", SEL_DNC, 32'd0);
        check_now();

        // Edit idle timeout
        set_keys(K_FIELD);
        n = 0;
        while (!EDIT_EN && n < 20) begin @(negedge CLK); n++; end
        expect_val("to_enter", SEL_EDIT, 32'd1);
        drain();
        @(posedge CLK); #1;
        set_keys(5'b0);
        n = 0;
        while (EDIT_EN && n < 52000) begin @(negedge CLK); n++; end
        check_val("to_window", 32'(n >= 44990 && n <= 50010), 32'd1);
        expect_val("to_exit", SEL_EDIT, 32'd0);
        expect_val("to_mode", SEL_MODE, 32'd0);
        check_now();

        // Alert from clock edit
        press(K_FIELD);
        expect_val("al_pre_edit", SEL_EDIT, 32'd1);
        check_now();
        pulse_done();
        expect_val("al_on", SEL_ALERT, 32'd1);
        expect_val("al_mode", SEL_MODE, 32'd2);
        expect_val("al_edit", SEL_EDIT, 32'd0);
        expect_val("al_field", SEL_FIELD, 32'd0);
        check_now();
        on_cnt = 0; off_cnt = 0; other_cnt = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge CLK);
            if (DISP_BLANK == 6'b111111) on_cnt++;
            else if (DISP_BLANK == 6'b000000) off_cnt++;
            else other_cnt++;
        end
        @(posedge CLK); #1;
        check_val("al_blank_on", 32'(on_cnt > 0), 32'd1);
        check_val("al_blank_off", 32'(off_cnt > 0), 32'd1);
        check_val("al_blank_other", 32'(other_cnt), 32'd0);
        press(K_DN);
        expect_val("al_exit", SEL_ALERT, 32'd0);
        expect_val("al_dn_eaten", SEL_DNC, 32'd0);
        expect_val("al_exit_mode", SEL_MODE, 32'd2);
        check_now();

        // Reset in ALERT, with MODE key held through release
        pulse_done();
        expect_val("al2_on", SEL_ALERT, 32'd1);
        check_now();
        set_keys(K_MODE);
        repeat (3) @(posedge CLK); #1;
        RSTN = 1'b0;
        #2;
        expect_reset("midrst");
        drain();
        repeat (3) @(posedge CLK); #1;
        RSTN = 1'b1;
        repeat (10) @(posedge CLK); #1;
        expect_val("held_nomode", SEL_MODE, 32'd0);
        expect_val("held_alert", SEL_ALERT, 32'd0);
        check_now();
        set_keys(5'b0);
        repeat (10) @(posedge CLK); #1;
        expect_val("release_nomode", SEL_MODE, 32'd0);
        check_now();
        check_val("stray_dst", 32'(stray_dst), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Front-panel controller for the DE2 digital clock. It owns the five push keys and the six HEX digits, and shares them between four function blocks: clock, alarm, countdown timer and stopwatch.
- Sequences view, edit and alert states. Routes key actions as one-cycle command pulses to the currently selected block.
- Selects which block's BCD digits are shown, and generates the blink mask for the field being edited.
- Sits between the key inputs and the clock/alarm/timer/stopwatch datapaths.

Parameters:
- CLK_PER_SEC, 5000: CLK cycles per second.
- BLINK_HALF, 2500: cycles per blink half-period.
- EDIT_TIMEOUT_S, 10: idle seconds before EDIT auto-exits.
- ALERT_S, 30: seconds before ALERT auto-exits.

Ports:
- CLK  in  1  system clock
- RSTN  in  1  asynchronous active-low reset
- KEY_MODE, KEY_FIELD, KEY_RUN, KEY_UP, KEY_DN  in  1 each  raw key levels, 1 = pressed, asynchronous to CLK
- CLK_BCD, ALM_BCD, TMR_BCD, SW_BCD  in  24 each  {H1,H0,M1,M0,S1,S0} BCD digits from each block
- TMR_ACTIVE  in  1  timer counting down
- TMR_DONE  in  1  one-cycle pulse when the timer reaches zero
- MODE  out  2  0 = clock, 1 = alarm, 2 = timer, 3 = stopwatch
- FIELD  out  2  0 = sec, 1 = min, 2 = hour
- EDIT_EN  out  1  high in EDIT
- DST  out  4  one-hot destination, valid with the pulses below
- UP_P, DN_P, RUN_P  out  1 each  one-cycle command pulses
- DISP_BCD  out  24  selected digits
- DISP_BLANK  out  6  1 = blank that digit, bit5 = H1
- ALERT  out  1  high in ALERT

Behaviour:
- Reset values: MODE=0, FIELD=0, EDIT_EN=0, DST=0, all pulses 0, DISP_BCD=0, DISP_BLANK=0, ALERT=0. Internally: FSM=VIEW, all counters 0.
- Key input: each key passes through a 2-flop synchronizer, then rising-edge detection. An event is one cycle; holding a key gives no repeat.
- One event per cycle. Priority: MODE > FIELD > RUN > UP > DN. Lower-priority events in the same cycle are discarded.
- Command timing: every command pulse is registered; it is asserted the cycle after the event is detected, together with DST = one-hot(MODE).

FSM states and transitions:
- VIEW:
  - MODE key: MODE increments with wrap 3→0.
  - FIELD key: enters EDIT with FIELD=0, but only if MODE is 0 or 1, or if MODE=2 with TMR_ACTIVE=0. Ignored otherwise.
  - RUN key: issues RUN_P when MODE is 2 or 3. Ignored for modes 0 and 1.
  - UP and DN keys: ignored.
- EDIT:
  - UP key: UP_P. DN key: DN_P.
  - FIELD key: FIELD steps 0→1→2. A press at FIELD=2 returns to VIEW with FIELD=0.
  - MODE key: returns to VIEW. MODE is unchanged.
  - RUN key: returns to VIEW. If MODE=2, also issues RUN_P.
  - Timeout: EDIT_EN drops to 0 and the state returns to VIEW after EDIT_TIMEOUT_S seconds with no key event. Any key event in EDIT restarts the idle count.
  - If TMR_ACTIVE rises while MODE=2, return to VIEW immediately.
- ALERT:
  - Entry: a TMR_DONE pulse in any state enters ALERT. MODE is forced to 2, FIELD=0, EDIT_EN=0.
  - Exit: the first key event, or ALERT_S seconds elapsed, returns to VIEW. The exiting key event is consumed: no pulse, no mode change.
  - A TMR_DONE pulse while already in ALERT restarts the alert timer.

Seconds base and blink:
- A CLK_PER_SEC divider free-runs and produces a one-cycle second tick. Timeouts count these ticks, so the expiry point has a −1 s / +0 s tolerance.
- The blink phase toggles every BLINK_HALF cycles.
- In EDIT, the blink counter and phase are cleared on each UP/DN event and on each FIELD change, so the edited digits are visible immediately.

Display:
- DISP_BCD is the registered mux of the four BCD inputs selected by MODE: one cycle of latency from a MODE or input change.
- DISP_BLANK in EDIT with phase=1: blank the two digits of FIELD (FIELD=0 → 6'b000011, 1 → 6'b001100, 2 → 6'b110000).
- DISP_BLANK in ALERT with phase=1: 6'b111111.
- DISP_BLANK otherwise: 0.

Reset mid-operation: asynchronous return to the reset values. Synchronizer flops also clear, so a key held through reset release produces no event.

Decomposition:
- Shared package clock_pkg:
  - mode enum (CLOCK, ALARM, TIMER, STOPWATCH)
  - field enum (SEC, MIN, HOUR)
  - FSM state enum (VIEW, EDIT, ALERT)
  - BCD bus width constant 24
- Sub-module key_edge: 2-flop synchronizer plus rising-edge detector. Instantiate it once per key.

Test Plan:
- Reset, then 5 MODE presses → MODE 1, 2, 3, 0, 1. DISP_BCD equals the selected *_BCD one cycle after each change. DST and all pulses stay 0.
- MODE=2, TMR_ACTIVE=0, FIELD key, then UP ×3 → EDIT_EN=1, FIELD=0, three UP_P pulses each with DST=4'b0100. A second FIELD press gives FIELD=1 and DISP_BLANK=6'b001100 during phase 1.
- MODE=3 with TMR_ACTIVE=1 at MODE=2: FIELD press → stays in VIEW. RUN at MODE=3 → RUN_P with DST=4'b1000.
- Same-cycle FIELD and UP edges in EDIT at FIELD=0 → FIELD=1, no UP_P.
- EDIT entered, no keys for EDIT_TIMEOUT_S × CLK_PER_SEC cycles → EDIT_EN=0 within the stated tolerance. MODE is unchanged.
- TMR_DONE pulse in EDIT at MODE=0 → ALERT=1, MODE=2, DISP_BLANK alternates 0 / 6'b111111. The next DN press → VIEW with no DN_P. RSTN asserted mid-ALERT → all reset values.
